fxp_cmult_pipe: RTL and testbench
=================================

FXP_CMULT_PIPE -- requirements
Module: fxp_cmult_pipe

Interface
REQ-001 SHALL have parameter N, default 16, meaning total operand/result width in bits (signed two's complement, N >= 4).
REQ-002 SHALL have parameter Q, default 8, meaning fractional bits of every operand and result (1 <= Q < N).
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports a_re, a_im  input  N each  operand A, real and imaginary parts.
REQ-006 SHALL have ports b_re, b_im  input  N each  operand B (twiddle), real and imaginary parts.
REQ-007 SHALL have port in_valid  input  1  operands valid this cycle.
REQ-008 SHALL have port in_ready  output  1  block accepts operands this cycle.
REQ-009 SHALL have ports p_re, p_im  output  N each  product A*B, Q fractional bits.
REQ-010 SHALL have port out_valid  output  1  p_re/p_im/ovf valid.
REQ-011 SHALL have port out_ready  input  1  downstream accepts result.
REQ-012 SHALL have port ovf  output  1  result was clipped (see REQ-022).

Function
REQ-013 SHALL compute p_re = a_re*b_re - a_im*b_im and p_im = a_re*b_im + a_im*b_re as signed fixed-point.
REQ-014 SHALL form the four products at full 2N-bit width and the sum/difference at 2N+1 bits; no intermediate truncation.
REQ-015 SHALL round by adding 2^(Q-1) to the 2N+1-bit sum, then arithmetic shift right by Q (round half toward +inf).
REQ-016 SHALL be a 3-stage pipeline: S1 registers operands, S2 registers four products, S3 registers rounded, range-reduced result; latency exactly 3 cycles when not stalled.
REQ-017 SHALL transfer on input when in_valid && in_ready, on output when out_valid && out_ready.
REQ-018 SHALL advance all stages together when adv = out_ready || !out_valid; in_ready = adv; when !adv every stage register and valid bit holds.
REQ-019 SHALL carry a valid bit per stage; a bubble (in_valid low while adv) propagates as an invalid stage.
REQ-020 SHALL sustain one accepted operand set per cycle while out_ready stays high.
REQ-021 SHALL hold p_re/p_im/ovf/out_valid stable while out_valid && !out_ready.
REQ-022 SHALL set ovf with its result when either component exceeds the N-bit range after shifting; ovf is 0 for in-range results.
REQ-023 SHALL treat the most negative operand (-2^(N-1)) as an ordinary value; -1.0*-1.0 in range yields the exact result, out of range follows REQ-022/REQ-030.

Reset
REQ-024 SHALL, while rst high, clear all stage valid bits, out_valid, ovf, p_re, p_im to 0 asynchronously.
REQ-025 SHALL discard all in-flight operands on reset mid-operation; no result for them ever appears.
REQ-026 SHALL drive in_ready = 1 in the first cycle after rst deasserts (pipeline empty).

Configuration
REQ-027 SHALL use macro FXP_CMULT_SAT_EN to select overflow handling.
REQ-028 SHALL, with FXP_CMULT_SAT_EN defined, clamp each component to 2^(N-1)-1 or -2^(N-1) on overflow, with ovf = 1.
REQ-029 SHALL, without FXP_CMULT_SAT_EN, keep the low N bits (wrap); ovf still reports the overflow.
REQ-030 SHALL have identical latency, handshake and in-range results in both builds.

Structure
REQ-031 SHALL place in shared package fxp_pkg: pipeline depth constant CMULT_LAT = 3 and a saturate/round helper function reused by FFT butterflies.
REQ-032 SHALL instantiate sub-module fxp_round_sat (one per component, parametrised N, Q) for the S3 round-and-range step.

Verification (N=16, Q=8)
REQ-033 SHALL check (1+j1)*(1-j1): a=0x0100/0x0100, b=0x0100/0xFF00 -> p=0x0200/0x0000, ovf 0, out_valid exactly 3 cycles after acceptance.
REQ-034 SHALL check rounding: a_re=0x0001, b_re=0x0080, imag 0 -> p_re=0x0001; a_re=0xFFFF, b_re=0x0080 -> p_re=0x0000.
REQ-035 SHALL check overflow: a_re=0x7F00, b_re=0x0200, imag 0 -> SAT_EN: p_re=0x7FFF, ovf 1; otherwise p_re=0xFE00, ovf 1.
REQ-036 SHALL check backpressure: 5 back-to-back inputs, out_ready low cycles 4-7 -> in_ready low while stalled, all 5 results in order, none dropped or duplicated.
REQ-037 SHALL check reset: assert rst with 3 results in flight -> out_valid 0 immediately, no stale result after release, next input's result correct at latency 3.

Source files
------------

// File: rtl/fxp_pkg.sv
// Shared fixed-point helpers: pipeline depth of the complex multiplier and a
// round-half-up / range-reduce function that the FFT butterflies also call.
package fxp_pkg;

    localparam int unsigned CMULT_LAT  = 3;
    localparam int unsigned FXP_WIDE_W = 64;

    typedef logic signed [FXP_WIDE_W-1:0] fxp_wide_t;

    // Rounded, range-reduced value (still wide) plus the overflow flag.
    typedef struct packed {
        logic      ovf;
        fxp_wide_t val;
    } fxp_rs_t;

    // Add 2^(q-1), arithmetic shift right by q, then check against the n-bit
    // signed range. With sat set, out-of-range values clamp to the rails;
    // otherwise the caller keeps the low n bits (wrap).
    // The input must already be sign-extended to FXP_WIDE_W (so 2N+1 <= 64).
    function automatic fxp_rs_t fxp_round_sat_f(
        input fxp_wide_t   x,
        input int unsigned n,
        input int unsigned q,
        input logic        sat
    );
        fxp_rs_t   res;
        fxp_wide_t r;
        fxp_wide_t hi;
        fxp_wide_t lo;
        r  = (x + (fxp_wide_t'(1) <<< (q - 1))) >>> q;
        hi = (fxp_wide_t'(1) <<< (n - 1)) - fxp_wide_t'(1);
        lo = -(fxp_wide_t'(1) <<< (n - 1));
        res.ovf = (r > hi) || (r < lo);
        res.val = r;
        if (sat && (r > hi)) begin
            res.val = hi;
        end else if (sat && (r < lo)) begin
            res.val = lo;
        end
        return res;
    endfunction

endpackage

// File: rtl/fxp_round_sat.sv
// Round-and-range step for one component of the complex product.
// FXP_CMULT_SAT_EN defined: clamp on overflow; undefined: wrap to N bits.
// ovf_c_o flags the overflow in both builds.
module fxp_round_sat
    import fxp_pkg::*;
#(
    parameter int unsigned N = 16,
    parameter int unsigned Q = 8
) (
    input  logic signed [2*N:0] sum_i,
    output logic [N-1:0]        res_c_o,
    output logic                ovf_c_o
);

`ifdef FXP_CMULT_SAT_EN
    localparam logic SAT = 1'b1;
`else
    localparam logic SAT = 1'b0;
`endif

    fxp_rs_t rs;

    // Round half toward +inf, shift out the extra fraction bits, reduce range.
    always_comb begin
        rs      = fxp_round_sat_f(fxp_wide_t'(sum_i), N, Q, SAT);
        res_c_o = N'(rs.val);
        ovf_c_o = rs.ovf;
    end

endmodule

// File: rtl/fxp_cmult_pipe.sv
// Pipelined signed fixed-point complex multiplier P = A * B.
// S1: operands, S2: four full-width products, S3: rounded/range-reduced result.
// All stages advance together when the output is empty or being taken.
// Overflow handling is selected by FXP_CMULT_SAT_EN (clamp) vs default (wrap).
module fxp_cmult_pipe
    import fxp_pkg::*;
#(
    parameter int unsigned N = 16,
    parameter int unsigned Q = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] a_re,
    input  logic [N-1:0] a_im,
    input  logic [N-1:0] b_re,
    input  logic [N-1:0] b_im,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [N-1:0] p_re,
    output logic [N-1:0] p_im,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         ovf
);

    localparam int unsigned PW = 2 * N;
    localparam int unsigned SW = 2 * N + 1;

    logic                 adv_c;

    logic signed [N-1:0]  a_re_q, a_im_q, b_re_q, b_im_q;
    logic                 v1_q;

    logic signed [PW-1:0] p_rr_d, p_ii_d, p_ri_d, p_ir_d;
    logic signed [PW-1:0] p_rr_q, p_ii_q, p_ri_q, p_ir_q;
    logic                 v2_q;

    logic signed [SW-1:0] sum_re_d, sum_im_d;
    logic [N-1:0]         p_re_d, p_im_d;
    logic                 ovf_re_c, ovf_im_c, ovf_d;

    logic [N-1:0]         p_re_q, p_im_q;
    logic                 ovf_q;
    logic                 v3_q;

    // Global advance: the output slot is empty or is being consumed.
    assign adv_c    = out_ready || !v3_q;
    assign in_ready = adv_c;

    // Full-width products and the exact 2N+1-bit sum/difference.
    always_comb begin
        p_rr_d   = PW'(a_re_q) * PW'(b_re_q);
        p_ii_d   = PW'(a_im_q) * PW'(b_im_q);
        p_ri_d   = PW'(a_re_q) * PW'(b_im_q);
        p_ir_d   = PW'(a_im_q) * PW'(b_re_q);
        sum_re_d = SW'(p_rr_q) - SW'(p_ii_q);
        sum_im_d = SW'(p_ri_q) + SW'(p_ir_q);
        ovf_d    = ovf_re_c || ovf_im_c;
    end

    fxp_round_sat #(.N(N), .Q(Q)) u_rs_re (
        .sum_i   (sum_re_d),
        .res_c_o (p_re_d),
        .ovf_c_o (ovf_re_c)
    );

    fxp_round_sat #(.N(N), .Q(Q)) u_rs_im (
        .sum_i   (sum_im_d),
        .res_c_o (p_im_d),
        .ovf_c_o (ovf_im_c)
    );

    // Pipeline registers; everything holds while the output is stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_re_q <= '0;
            a_im_q <= '0;
            b_re_q <= '0;
            b_im_q <= '0;
            v1_q   <= 1'b0;
            p_rr_q <= '0;
            p_ii_q <= '0;
            p_ri_q <= '0;
            p_ir_q <= '0;
            v2_q   <= 1'b0;
            p_re_q <= '0;
            p_im_q <= '0;
            ovf_q  <= 1'b0;
            v3_q   <= 1'b0;
        end else if (adv_c) begin
            a_re_q <= a_re;
            a_im_q <= a_im;
            b_re_q <= b_re;
            b_im_q <= b_im;
            v1_q   <= in_valid;
            p_rr_q <= p_rr_d;
            p_ii_q <= p_ii_d;
            p_ri_q <= p_ri_d;
            p_ir_q <= p_ir_d;
            v2_q   <= v1_q;
            p_re_q <= p_re_d;
            p_im_q <= p_im_d;
            ovf_q  <= ovf_d && v2_q;
            v3_q   <= v2_q;
        end
    end

    assign p_re      = p_re_q;
    assign p_im      = p_im_q;
    assign ovf       = ovf_q;
    assign out_valid = v3_q;

endmodule

// File: tb/tb_fxp_cmult_pipe.sv
// Directed bench for fxp_cmult_pipe at N=16, Q=8.
module tb_fxp_cmult_pipe;
    import fxp_pkg::*;

    localparam int unsigned N = 16;
    localparam int unsigned Q = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [N-1:0] a_re, a_im, b_re, b_im;
    logic         in_valid, in_ready;
    logic [N-1:0] p_re, p_im;
    logic         out_valid, out_ready, ovf;

    int checks   = 0;
    int failures = 0;

    fxp_cmult_pipe #(.N(N), .Q(Q)) dut (
        .clk       (clk),
        .rst       (rst),
        .a_re      (a_re),
        .a_im      (a_im),
        .b_re      (b_re),
        .b_im      (b_im),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .p_re      (p_re),
        .p_im      (p_im),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One transaction with the output always ready; checks latency and result.
    task automatic run_one(input logic [N-1:0] ar, input logic [N-1:0] ai,
                           input logic [N-1:0] br, input logic [N-1:0] bi,
                           input logic [N-1:0] er, input logic [N-1:0] ei,
                           input logic eo, input string name);
        int cyc;
        out_ready = 1'b1;
        a_re = ar; a_im = ai; b_re = br; b_im = bi;
        in_valid = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s in_ready got=%b exp=1", name, in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        cyc = 1;
        while (out_valid !== 1'b1 && cyc < 10) begin
            @(posedge clk); #1;
            cyc++;
        end
        checks++;
        if (cyc !== int'(CMULT_LAT)) begin
            failures++;
            $display("FAIL %s latency got=%0d exp=%0d", name, cyc, CMULT_LAT);
        end
        checks++;
        if (p_re !== er) begin
            failures++;
            $display("FAIL %s p_re got=%h exp=%h", name, p_re, er);
        end
        checks++;
        if (p_im !== ei) begin
            failures++;
            $display("FAIL %s p_im got=%h exp=%h", name, p_im, ei);
        end
        checks++;
        if (ovf !== eo) begin
            failures++;
            $display("FAIL %s ovf got=%b exp=%b", name, ovf, eo);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        in_valid = 1'b0; out_ready = 1'b1;
        a_re = '0; a_im = '0; b_re = '0; b_im = '0;
        #1 rst = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0 || ovf !== 1'b0 || p_re !== 16'h0000 || p_im !== 16'h0000) begin
            failures++;
            $display("FAIL reset_outputs got v=%b ovf=%b re=%h im=%h exp all 0",
                     out_valid, ovf, p_re, p_im);
        end
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready got=%b exp=1", in_ready);
        end
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_out_valid got=%b exp=0", out_valid);
        end
    endtask

    task automatic test_basic;
        // (1+j1)*(1-j1) = 2
        run_one(16'h0100, 16'h0100, 16'h0100, 16'hFF00, 16'h0200, 16'h0000, 1'b0, "conj_pair");
        // (2+j3)*(0.5-j0.25) = 1.75+j1.0
        run_one(16'h0200, 16'h0300, 16'h0080, 16'hFFC0, 16'h01C0, 16'h0100, 1'b0, "general");
        // -1.0 * -1.0 = 1.0 exactly
        run_one(16'hFF00, 16'h0000, 16'hFF00, 16'h0000, 16'h0100, 16'h0000, 1'b0, "neg_one_sq");
    endtask

    task automatic test_rounding;
        run_one(16'h0001, 16'h0000, 16'h0080, 16'h0000, 16'h0001, 16'h0000, 1'b0, "round_pos_half");
        run_one(16'hFFFF, 16'h0000, 16'h0080, 16'h0000, 16'h0000, 16'h0000, 1'b0, "round_neg_half");
    endtask

    task automatic test_overflow;
`ifdef FXP_CMULT_SAT_EN
        run_one(16'h7F00, 16'h0000, 16'h0200, 16'h0000, 16'h7FFF, 16'h0000, 1'b1, "ovf_pos");
        run_one(16'h8000, 16'h0000, 16'h8000, 16'h0000, 16'h7FFF, 16'h0000, 1'b1, "ovf_min_sq");
        run_one(16'h8000, 16'h0000, 16'h0200, 16'h0000, 16'h8000, 16'h0000, 1'b1, "ovf_neg");
`else
        run_one(16'h7F00, 16'h0000, 16'h0200, 16'h0000, 16'hFE00, 16'h0000, 1'b1, "ovf_pos");
        run_one(16'h8000, 16'h0000, 16'h8000, 16'h0000, 16'h0000, 16'h0000, 1'b1, "ovf_min_sq");
        run_one(16'h8000, 16'h0000, 16'h0200, 16'h0000, 16'h0000, 16'h0000, 1'b1, "ovf_neg");
`endif
    endtask

    // Five back-to-back inputs (k+j1)*2, output stalled in cycles 4..7.
    task automatic test_back_to_back;
        logic [N-1:0] exp_re [5];
        int  sent = 0;
        int  rcv  = 0;
        int  stalls = 0;
        logic in_fire, out_fire;
        for (int k = 0; k < 5; k++) exp_re[k] = N'((k + 1) * 512);
        for (int cyc = 0; cyc < 20; cyc++) begin
            in_valid  = (sent < 5);
            a_re      = N'((sent + 1) * 256);
            a_im      = 16'h0100;
            b_re      = 16'h0200;
            b_im      = 16'h0000;
            out_ready = !(cyc >= 4 && cyc <= 7);
            #1;
            in_fire  = in_valid && in_ready;
            out_fire = out_valid && out_ready;
            if (out_valid === 1'b1) begin
                checks++;
                if (rcv >= 5) begin
                    failures++;
                    $display("FAIL bp_extra_result cycle=%0d got re=%h exp none", cyc, p_re);
                end else if (p_re !== exp_re[rcv] || p_im !== 16'h0200 || ovf !== 1'b0) begin
                    failures++;
                    $display("FAIL bp_result idx=%0d got re=%h im=%h ovf=%b exp re=%h im=0200 ovf=0",
                             rcv, p_re, p_im, ovf, exp_re[rcv]);
                end
                if (!out_ready) begin
                    stalls++;
                    checks++;
                    if (in_ready !== 1'b0) begin
                        failures++;
                        $display("FAIL bp_in_ready_stall cycle=%0d got=%b exp=0", cyc, in_ready);
                    end
                end
            end
            @(posedge clk); #1;
            if (in_fire) sent++;
            if (out_fire) rcv++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        checks++;
        if (rcv !== 5 || sent !== 5) begin
            failures++;
            $display("FAIL bp_counts got sent=%0d rcv=%0d exp 5/5", sent, rcv);
        end
        checks++;
        if (stalls !== 4) begin
            failures++;
            $display("FAIL bp_stall_cycles got=%0d exp=4", stalls);
        end
    endtask

    // Reset with three results in flight; none may appear afterwards.
    task automatic test_reset_midflight;
        int seen = 0;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            a_re = N'((k + 1) * 256); a_im = 16'h0000;
            b_re = 16'h0100;          b_im = 16'h0000;
            in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid_prefill out_valid got=%b exp=1", out_valid);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || p_re !== 16'h0000 || p_im !== 16'h0000 || ovf !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_async got v=%b re=%h im=%h ovf=%b exp all 0",
                     out_valid, p_re, p_im, ovf);
        end
        @(posedge clk);
        @(negedge clk); rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) seen++;
        end
        checks++;
        if (seen !== 0) begin
            failures++;
            $display("FAIL rst_mid_stale got=%0d results exp=0", seen);
        end
        run_one(16'h0180, 16'h0040, 16'h0200, 16'h0100, 16'h02C0, 16'h0200, 1'b0, "rst_mid_next");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_rounding();
        test_overflow();
        test_back_to_back();
        test_reset_midflight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
